// File: rtl/exception_sequencer_if.sv
// ---------------------------------------------------------------------------
// exception_sequencer_if
//   Groups the signals between the main control / datapath and the exception
//   sequencer.
//   master : control/datapath side. It drives the exception flags, the
//            control unit's address-select code, the PC and the memory data.
//            It receives the mux select, the EPC/PC write strobes and values,
//            the cause, busy and exc_done.
//   slave  : exception sequencer side (the mirror of master).
// ---------------------------------------------------------------------------
interface exception_sequencer_if;
   logic        overflow;
   logic        div_zero;
   logic        bad_opcode;
   logic [2:0]  ctrl_iord;
   logic [31:0] pc_in;
   logic [31:0] mem_data;

   logic [2:0]  iord;
   logic        epc_wr;
   logic [31:0] epc_value;
   logic [1:0]  cause;
   logic        pc_wr;
   logic [31:0] pc_value;
   logic        busy;
   logic        exc_done;

   modport master (
      output overflow, div_zero, bad_opcode, ctrl_iord, pc_in, mem_data,
      input  iord, epc_wr, epc_value, cause, pc_wr, pc_value, busy, exc_done
   );

   modport slave (
      input  overflow, div_zero, bad_opcode, ctrl_iord, pc_in, mem_data,
      output iord, epc_wr, epc_value, cause, pc_wr, pc_value, busy, exc_done
   );
endinterface

// File: rtl/exception_sequencer.sv
// ---------------------------------------------------------------------------
// exception_sequencer
//   Multicycle controller that takes over the memory address select and the
//   PC/EPC write strobes when the datapath raises an exception. While idle it
//   passes the control unit's address-select code through unchanged. On
//   overflow, divide-by-zero or bad opcode it saves PC-4 into EPC, steers the
//   address mux to the matching vector, waits MEM_WAIT extra cycles for the
//   memory, and loads the handler byte into PC.
//
// Parameters
//   MEM_WAIT : extra memory cycles after address select (0..7)
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : slave modport of exception_sequencer_if
//              in : overflow, div_zero, bad_opcode, ctrl_iord, pc_in, mem_data
//              out: iord, epc_wr, epc_value, cause, pc_wr, pc_value, busy,
//                   exc_done
// ---------------------------------------------------------------------------
module exception_sequencer #(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   exception_sequencer_if.slave  bus
);

   localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

   typedef enum logic [2:0] {
      IDLE,
      SAVE,
      ADDR,
      LOAD,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  wait_cnt;
   logic [1:0]  cause_r;
   logic [31:0] epc_r;
   logic [31:0] pc_r;

   logic        flag_any;
   logic [2:0]  vec_sel;

   logic [2:0]  iord_c;
   logic        epc_wr_c;
   logic        pc_wr_c;
   logic        busy_c;
   logic        exc_done_c;

   // Priority encode the exception flags: overflow > div_zero > bad_opcode.
   function automatic logic [1:0] cause_sel(input logic ov, input logic dz,
                                             input logic bo);
      logic [1:0] c;
      c = 2'd0;
      if (ov)      c = 2'd1;
      else if (dz) c = 2'd2;
      else if (bo) c = 2'd3;
      return c;
   endfunction

   assign flag_any = bus.overflow | bus.div_zero | bus.bad_opcode;
   // Vector codes 2/3/4 sit directly above the cause codes 1/2/3.
   assign vec_sel  = {1'b0, cause_r} + 3'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= 3'd0;
         cause_r  <= 2'd0;
         epc_r    <= 32'd0;
         pc_r     <= 32'd0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (flag_any) begin
                  cause_r <= cause_sel(bus.overflow, bus.div_zero, bus.bad_opcode);
                  // pc_in is already PC+4; EPC gets the faulting instruction.
                  epc_r   <= bus.pc_in - 32'd4;
               end
            end
            SAVE: wait_cnt <= WAIT_INIT;
            ADDR: begin
               if (wait_cnt != 3'd0) begin
                  wait_cnt <= wait_cnt - 3'd1;
               end else begin
                  // Last ADDR cycle: memory data is valid now.
                  pc_r <= {24'd0, bus.mem_data[7:0]};
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      iord_c     = 3'd0;
      epc_wr_c   = 1'b0;
      pc_wr_c    = 1'b0;
      busy_c     = 1'b1;
      exc_done_c = 1'b0;
      case (state)
         IDLE: begin
            busy_c = 1'b0;
            iord_c = bus.ctrl_iord;
            if (flag_any) state_nxt = SAVE;
         end
         SAVE: begin
            epc_wr_c  = 1'b1;
            state_nxt = ADDR;
         end
         ADDR: begin
            iord_c = vec_sel;
            if (wait_cnt == 3'd0) state_nxt = LOAD;
         end
         LOAD: begin
            iord_c    = vec_sel;
            pc_wr_c   = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            exc_done_c = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A reset cycle must never emit a strobe, whatever state it interrupts.
      if (reset) begin
         iord_c     = 3'd0;
         epc_wr_c   = 1'b0;
         pc_wr_c    = 1'b0;
         busy_c     = 1'b0;
         exc_done_c = 1'b0;
      end
   end

   assign bus.iord      = iord_c;
   assign bus.epc_wr    = epc_wr_c;
   assign bus.epc_value = epc_r;
   assign bus.cause     = cause_r;
   assign bus.pc_wr     = pc_wr_c;
   assign bus.pc_value  = pc_r;
   assign bus.busy      = busy_c;
   assign bus.exc_done  = exc_done_c;

endmodule

// File: tb/tb_exception_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exception_sequencer
//   Drives two sequencers (MEM_WAIT=2 and MEM_WAIT=0) with identical inputs.
//   The reference model tracks, per instance, the edge at which the current
//   exception was accepted and derives every expected output from the cycle
//   offset since that edge.
// ---------------------------------------------------------------------------
module tb_exception_sequencer;

   localparam int MW0 = 2;
   localparam int MW1 = 0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   exception_sequencer_if bus0();
   exception_sequencer_if bus1();

   exception_sequencer #(.MEM_WAIT(MW0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
   exception_sequencer #(.MEM_WAIT(MW1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

   int n_chk  = 0;
   int n_pass = 0;

   // Current stimulus
   logic        s_ov, s_dz, s_bo, s_rs;
   logic [2:0]  s_ci;
   logic [31:0] s_pc, s_md;

   // Reference model state
   int          mw      [2] = '{MW0, MW1};
   int          cyc     = 0;
   int          start   [2] = '{-1, -1};
   logic [1:0]  m_cause [2] = '{2'd0, 2'd0};
   logic [31:0] m_epc   [2] = '{32'd0, 32'd0};
   logic [31:0] m_pc    [2] = '{32'd0, 32'd0};
   bit          chk_en  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   function automatic bit in_seq(input int i);
      return (start[i] >= 0) && ((cyc - start[i]) < 5 + mw[i]);
   endfunction

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         int          d;
         bit          act;
         logic [2:0]  e_iord;
         string       p;
         d   = cyc - start[i];
         act = in_seq(i) && !s_rs;
         p   = (i == 0) ? "mw2" : "mw0";
         if (s_rs)                           e_iord = 3'd0;
         else if (!act)                      e_iord = s_ci;
         else if (d >= 2 && d <= 3 + mw[i])  e_iord = {1'b0, m_cause[i]} + 3'd1;
         else                                e_iord = 3'd0;
         chk({p, "_iord"},     (i == 0) ? bus0.iord      : bus1.iord,      e_iord);
         chk({p, "_busy"},     (i == 0) ? bus0.busy      : bus1.busy,      act);
         chk({p, "_epc_wr"},   (i == 0) ? bus0.epc_wr    : bus1.epc_wr,    act && d == 1);
         chk({p, "_pc_wr"},    (i == 0) ? bus0.pc_wr     : bus1.pc_wr,     act && d == 3 + mw[i]);
         chk({p, "_exc_done"}, (i == 0) ? bus0.exc_done  : bus1.exc_done,  act && d == 4 + mw[i]);
         chk({p, "_cause"},    (i == 0) ? bus0.cause     : bus1.cause,     m_cause[i]);
         chk({p, "_epc_val"},  (i == 0) ? bus0.epc_value : bus1.epc_value, m_epc[i]);
         chk({p, "_pc_val"},   (i == 0) ? bus0.pc_value  : bus1.pc_value,  m_pc[i]);
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (s_rs) begin
            start[i]   = -1;
            m_cause[i] = 2'd0;
            m_epc[i]   = 32'd0;
            m_pc[i]    = 32'd0;
         end else if (!in_seq(i)) begin
            if (s_ov || s_dz || s_bo) begin
               start[i]   = cyc;
               m_cause[i] = s_ov ? 2'd1 : (s_dz ? 2'd2 : 2'd3);
               m_epc[i]   = s_pc - 32'd4;
            end
         end else if (cyc - start[i] == 2 + mw[i]) begin
            m_pc[i] = {24'd0, s_md[7:0]};
         end
      end
      cyc++;
   endtask

   task automatic step(input logic ov, input logic dz, input logic bo,
                       input logic [2:0] ci, input logic [31:0] pc,
                       input logic [31:0] md, input logic rs);
      @(negedge clk);
      s_ov = ov; s_dz = dz; s_bo = bo; s_ci = ci; s_pc = pc; s_md = md; s_rs = rs;
      reset = rs;
      bus0.overflow = ov; bus0.div_zero = dz; bus0.bad_opcode = bo;
      bus0.ctrl_iord = ci; bus0.pc_in = pc; bus0.mem_data = md;
      bus1.overflow = ov; bus1.div_zero = dz; bus1.bad_opcode = bo;
      bus1.ctrl_iord = ci; bus1.pc_in = pc; bus1.mem_data = md;
      #1;
      if (chk_en) check_all();
      @(posedge clk);
      model_edge();
   endtask

   task automatic quiet(input int n, input logic [31:0] pc, input logic [31:0] md);
      for (int k = 0; k < n; k++)
         step(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)), pc, md, 1'b0);
   endtask

   initial begin
      // Registers are unknown before the first reset edge.
      step(1'b0, 1'b0, 1'b0, 3'd5, 32'd0, 32'd0, 1'b1);
      chk_en = 1'b1;
      step(1'b0, 1'b0, 1'b0, 3'd6, 32'd0, 32'd0, 1'b1);

      // Idle pass-through of every select code.
      for (int v = 0; v < 8; v++)
         step(1'b0, 1'b0, 1'b0, 3'(v), 32'd0, 32'd0, 1'b0);

      // Single overflow.
      step(1'b1, 1'b0, 1'b0, 3'd1, 32'h0000_0108, 32'hAABB_CC5C, 1'b0);
      quiet(8, 32'h0000_0108, 32'hAABB_CC5C);

      // All flags together, then div_zero + bad_opcode.
      step(1'b1, 1'b1, 1'b1, 3'd5, 32'h0000_2000, 32'h0000_0033, 1'b0);
      quiet(8, 32'h0000_2000, 32'h0000_0033);
      step(1'b0, 1'b1, 1'b1, 3'd5, 32'h0000_3000, 32'h0000_0044, 1'b0);
      quiet(8, 32'h0000_3000, 32'h0000_0044);

      // bad_opcode at pc_in=0 (EPC wraps); div_zero during ADDR is ignored.
      step(1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 32'h0000_00E7, 1'b0);
      quiet(2, 32'd0, 32'h0000_00E7);
      step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'h0000_00E7, 1'b0);
      quiet(6, 32'd0, 32'h0000_00E7);

      // Reset in the middle of ADDR.
      step(1'b1, 1'b0, 1'b0, 3'd3, 32'h0000_0400, 32'h0000_0011, 1'b0);
      quiet(2, 32'h0000_0400, 32'h0000_0011);
      step(1'b0, 1'b0, 1'b0, 3'd3, 32'h0000_0400, 32'h0000_0011, 1'b1);
      quiet(6, 32'h0000_0400, 32'h0000_0011);

      // Flag held high: back-to-back sequences.
      for (int k = 0; k < 16; k++)
         step(1'b0, 1'b1, 1'b0, 3'd7, 32'h0000_0800, 32'h0000_0099, 1'b0);
      quiet(8, 32'h0000_0800, 32'h0000_0099);

      // Random traffic.
      for (int k = 0; k < 500; k++)
         step(($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 11) == 0), 3'($urandom_range(0, 7)),
              $urandom(), $urandom(), ($urandom_range(0, 59) == 0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
